tcdm_rr_merge_4to1: RTL and testbench
=====================================

TCDM_RR_MERGE_4TO1 -- requirements
Module: tcdm_rr_merge_4to1

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: TCDM address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: TCDM data width; BE width is DATA_WIDTH/8.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, power of two ≥2: maximum outstanding requests.
REQ-004 SHALL use one clock and an asynchronous, active-low reset, on the ports below.
REQ-005 clk_i  in  1  sole clock; all state updates on the rising edge.
REQ-006 rst_ni  in  1  asynchronous active-low reset.
REQ-007 in_req_i  in  [3:0]  per-port request; ports 0-1 carry the write path, ports 2-3 the read path of the upstream AXI-to-TCDM bridge.
REQ-008 in_add_i / in_wen_i / in_wdata_i / in_be_i  in  [3:0] x ADDR_WIDTH / 1 / DATA_WIDTH / DATA_WIDTH/8  per-port request payload; wen=1 read, wen=0 write.
REQ-009 in_gnt_o  out  [3:0]  per-port grant.
REQ-010 in_r_valid_o  out  [3:0]  per-port response valid.
REQ-011 in_r_rdata_o / in_r_opc_o  out  DATA_WIDTH / 1  response data and error, broadcast to all ports.
REQ-012 out_req_o, out_add_o, out_wen_o, out_wdata_o, out_be_o  out  1 / ADDR_WIDTH / 1 / DATA_WIDTH / DATA_WIDTH/8  merged request toward the memory-side TCDM port.
REQ-013 out_gnt_i  in  1  memory-side grant.
REQ-014 out_r_valid_i, out_r_rdata_i, out_r_opc_i  in  1 / DATA_WIDTH / 1  memory-side response.
REQ-015 err_o  out  1  sticky flag: response received with no outstanding request.

Function
REQ-016 SHALL keep a 2-bit round-robin pointer rr_q; the selected port sel is the first port with in_req_i set, searching rr_q, rr_q+1, ... modulo 4.
REQ-017 out_req_o SHALL be (|in_req_i) AND NOT fifo_full, combinationally; out_add/wen/wdata/be SHALL equal the payload of port sel.
REQ-018 in_gnt_o[sel] SHALL be out_gnt_i AND out_req_o; all other grant bits SHALL be 0.
REQ-019 On a handshake (out_req_o AND out_gnt_i), sel SHALL be pushed into the ID FIFO and rr_q SHALL become (sel+1) mod 4 at the next edge; without a handshake rr_q SHALL hold.
REQ-020 Every accepted request, read or write, SHALL expect exactly one out_r_valid_i, returned in order, at least one cycle after grant.
REQ-021 On out_r_valid_i with the FIFO non-empty, the FIFO head SHALL be popped and in_r_valid_o[head] SHALL be 1 in the same cycle; all other bits SHALL be 0.
REQ-022 in_r_rdata_o and in_r_opc_o SHALL equal out_r_rdata_i and out_r_opc_i combinationally.
REQ-023 On out_r_valid_i with the FIFO empty, the response SHALL be dropped, in_r_valid_o SHALL be all 0, and err_o SHALL be set until reset.
REQ-024 When the FIFO holds FIFO_DEPTH entries, out_req_o and all in_gnt_o SHALL be 0, even if a pop occurs in the same cycle.
REQ-025 A push and a pop in the same cycle SHALL leave the occupancy unchanged and SHALL not corrupt the head or tail.
REQ-026 The FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL be a log2(FIFO_DEPTH)+1-bit counter.
REQ-027 in_gnt_o and in_r_valid_o SHALL never have more than one bit set.

Reset
REQ-028 While rst_ni=0, the following SHALL hold asynchronously: rr_q=0, FIFO empty (pointers and count 0), err_o=0.
REQ-029 Consequently, during reset in_gnt_o=0 and in_r_valid_o=0; out_req_o follows in_req_i.
REQ-030 On reset assertion mid-transaction, outstanding IDs SHALL be discarded; responses arriving after reset release SHALL set err_o per REQ-023.

Verification
REQ-031 Single port: in_req_i=4'b0100, add=0x1000_0008, wen=1, out_gnt_i=1; rdata 0xDEAD_BEEF returned 1 cycle later -> in_gnt_o=4'b0100, then in_r_valid_o=4'b0100, in_r_rdata_o=0xDEAD_BEEF.
REQ-032 Fairness: in_req_i=4'b1111 held, out_gnt_i=1 always -> grant order 0,1,2,3,0,... with one grant per cycle.
REQ-033 Backpressure: FIFO_DEPTH=4, out_gnt_i=1, no responses for 6 cycles -> exactly 4 grants, then out_req_o=0 until the first response arrives.
REQ-034 Ordering: grant ports 3,0,2, then return responses with rdata 0xA, 0xB, 0xC -> in_r_valid_o pulses 4'b1000, 4'b0001, 4'b0100 with the matching data.
REQ-035 Spurious response: FIFO empty, out_r_valid_i=1 -> in_r_valid_o=0, err_o=1 until rst_ni=0.
REQ-036 Reset mid-flight: 2 outstanding requests, pulse rst_ni low -> FIFO empty, rr_q=0, err_o=0; the next request from port 2 is granted first.

Source files
------------

// File: rtl/tcdm_rr_merge_4to1.sv
// Four-to-one TCDM request merger with round-robin arbitration and an
// in-order ID FIFO that routes memory responses back to the issuing port.
module tcdm_rr_merge_4to1 #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [3:0]                          in_req_i,
    input  logic [3:0][ADDR_WIDTH-1:0]          in_add_i,
    input  logic [3:0]                          in_wen_i,
    input  logic [3:0][DATA_WIDTH-1:0]          in_wdata_i,
    input  logic [3:0][DATA_WIDTH/8-1:0]        in_be_i,
    output logic [3:0]                          in_gnt_o,
    output logic [3:0]                          in_r_valid_o,
    output logic [DATA_WIDTH-1:0]               in_r_rdata_o,
    output logic                                in_r_opc_o,
    output logic                                out_req_o,
    output logic [ADDR_WIDTH-1:0]               out_add_o,
    output logic                                out_wen_o,
    output logic [DATA_WIDTH-1:0]               out_wdata_o,
    output logic [DATA_WIDTH/8-1:0]             out_be_o,
    input  logic                                out_gnt_i,
    input  logic                                out_r_valid_i,
    input  logic [DATA_WIDTH-1:0]               out_r_rdata_i,
    input  logic                                out_r_opc_i,
    output logic                                err_o
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [1:0]       rr_q;
    logic [1:0]       sel;
    logic [1:0]       ids_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wptr_q;
    logic [PTR_W-1:0] rptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic [1:0]       head;

    assign fifo_full  = (cnt_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (cnt_q == '0);
    assign head       = ids_q[rptr_q];

    // Round-robin search starting at rr_q for the first requesting port.
    always_comb begin
        logic [1:0] idx;
        logic       found;
        sel   = rr_q;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = rr_q + 2'(i);
            if (!found && in_req_i[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    // Merged request is blocked only by a full ID FIFO; payload follows sel.
    assign out_req_o   = (|in_req_i) && !fifo_full;
    assign out_add_o   = in_add_i[sel];
    assign out_wen_o   = in_wen_i[sel];
    assign out_wdata_o = in_wdata_i[sel];
    assign out_be_o    = in_be_i[sel];

    // Grants are suppressed while reset is held so no port sees a phantom accept.
    assign push = out_req_o && out_gnt_i && rst_ni;
    assign pop  = out_r_valid_i && !fifo_empty;

    // One-hot grant toward the selected port.
    always_comb begin
        in_gnt_o = '0;
        if (push) in_gnt_o[sel] = 1'b1;
    end

    // One-hot response valid toward the port at the FIFO head.
    always_comb begin
        in_r_valid_o = '0;
        if (pop) in_r_valid_o[head] = 1'b1;
    end

    assign in_r_rdata_o = out_r_rdata_i;
    assign in_r_opc_o   = out_r_opc_i;
    assign err_o        = err_q;

    // Round-robin pointer advances past the port that just won.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)   rr_q <= '0;
        else if (push) rr_q <= sel + 2'd1;
    end

    // ID FIFO storage, pointers and occupancy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < FIFO_DEPTH; i++) ids_q[i] <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) begin
                ids_q[wptr_q] <= sel;
                wptr_q        <= wptr_q + PTR_W'(1);
            end
            if (pop) rptr_q <= rptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Sticky error on a response with nothing outstanding.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                         err_q <= 1'b0;
        else if (out_r_valid_i && fifo_empty) err_q <= 1'b1;
    end

endmodule

// File: tb/tb_tcdm_rr_merge_4to1.sv
// Directed bench for tcdm_rr_merge_4to1 with an ID scoreboard queue.
module tb_tcdm_rr_merge_4to1;

    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;

    logic                  clk_i = 1'b0;
    logic                  rst_ni;
    logic [3:0]            in_req_i;
    logic [3:0][AW-1:0]    in_add_i;
    logic [3:0]            in_wen_i;
    logic [3:0][DW-1:0]    in_wdata_i;
    logic [3:0][DW/8-1:0]  in_be_i;
    logic [3:0]            in_gnt_o;
    logic [3:0]            in_r_valid_o;
    logic [DW-1:0]         in_r_rdata_o;
    logic                  in_r_opc_o;
    logic                  out_req_o;
    logic [AW-1:0]         out_add_o;
    logic                  out_wen_o;
    logic [DW-1:0]         out_wdata_o;
    logic [DW/8-1:0]       out_be_o;
    logic                  out_gnt_i;
    logic                  out_r_valid_i;
    logic [DW-1:0]         out_r_rdata_i;
    logic                  out_r_opc_i;
    logic                  err_o;

    tcdm_rr_merge_4to1 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .in_req_i(in_req_i), .in_add_i(in_add_i), .in_wen_i(in_wen_i),
        .in_wdata_i(in_wdata_i), .in_be_i(in_be_i),
        .in_gnt_o(in_gnt_o), .in_r_valid_o(in_r_valid_o),
        .in_r_rdata_o(in_r_rdata_o), .in_r_opc_o(in_r_opc_o),
        .out_req_o(out_req_o), .out_add_o(out_add_o), .out_wen_o(out_wen_o),
        .out_wdata_o(out_wdata_o), .out_be_o(out_be_o), .out_gnt_i(out_gnt_i),
        .out_r_valid_i(out_r_valid_i), .out_r_rdata_i(out_r_rdata_i),
        .out_r_opc_i(out_r_opc_i), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [1:0] model_q [$];
    logic [1:0] model_rr;
    logic       model_err;
    logic [3:0] obs_gnt;
    logic [3:0] obs_rv;
    logic       obs_req;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] model_sel(input logic [3:0] req);
        logic [1:0] idx;
        for (int i = 3; i >= 0; i--) begin
            idx = model_rr + 2'(i);
            if (req[idx]) model_sel = idx;
        end
        if (req == 4'b0) model_sel = model_rr;
    endfunction

    // One clock of stimulus: drive, check combinational outputs, update model, clock, check err.
    task automatic cycle(input logic [3:0] req, input logic gnt, input logic rv, input logic [31:0] rdata);
        logic       exp_req;
        logic [1:0] es;
        logic [3:0] eg;
        logic [3:0] erv;
        in_req_i      = req;
        out_gnt_i     = gnt;
        out_r_valid_i = rv;
        out_r_rdata_i = rdata;
        out_r_opc_i   = rdata[0];
        #1;
        exp_req = (req != 4'b0) && (model_q.size() < DEPTH);
        es      = model_sel(req);
        eg      = (exp_req && gnt) ? (4'b0001 << es) : 4'b0000;
        erv     = (rv && model_q.size() > 0) ? (4'b0001 << model_q[0]) : 4'b0000;
        check("out_req", 64'(out_req_o), 64'(exp_req));
        check("in_gnt", 64'(in_gnt_o), 64'(eg));
        check("in_r_valid", 64'(in_r_valid_o), 64'(erv));
        if (rv) begin
            check("rdata", 64'(in_r_rdata_o), 64'(rdata));
            check("opc", 64'(in_r_opc_o), 64'(rdata[0]));
        end
        if (exp_req) begin
            check("out_add", 64'(out_add_o), 64'(in_add_i[es]));
            check("out_wen", 64'(out_wen_o), 64'(in_wen_i[es]));
            check("out_wdata", 64'(out_wdata_o), 64'(in_wdata_i[es]));
        end
        obs_gnt = in_gnt_o;
        obs_rv  = in_r_valid_o;
        obs_req = out_req_o;
        if (erv != 4'b0) void'(model_q.pop_front());
        else if (rv) model_err = 1'b1;
        if (eg != 4'b0) begin
            model_q.push_back(es);
            model_rr = es + 2'd1;
        end
        @(posedge clk_i);
        #1;
        check("err", 64'(err_o), 64'(model_err));
    endtask

    // Assert reset between edges, check asynchronous effects, then release.
    task automatic do_reset();
        in_req_i      = 4'b0100;
        out_gnt_i     = 1'b1;
        out_r_valid_i = 1'b0;
        rst_ni        = 1'b0;
        #1;
        check("rst_err", 64'(err_o), 64'd0);
        check("rst_gnt", 64'(in_gnt_o), 64'd0);
        check("rst_rv", 64'(in_r_valid_o), 64'd0);
        check("rst_req_follows", 64'(out_req_o), 64'd1);
        model_q.delete();
        model_rr  = 2'd0;
        model_err = 1'b0;
        #1;
        rst_ni = 1'b1;
    endtask

    initial begin
        int         grants;
        logic [3:0] fair_exp [8];
        fair_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        for (int p = 0; p < 4; p++) begin
            in_add_i[p]   = 32'h1000_0000 + 32'(p * 4);
            in_wen_i[p]   = (p >= 2);
            in_wdata_i[p] = 32'hC0DE_0000 + 32'(p);
            in_be_i[p]    = 4'(4'b0001 << p);
        end
        in_req_i = '0; out_gnt_i = 1'b0; out_r_valid_i = 1'b0;
        out_r_rdata_i = '0; out_r_opc_i = 1'b0;
        rst_ni = 1'b0; model_rr = '0; model_err = 1'b0;
        obs_gnt = '0; obs_rv = '0; obs_req = 1'b0;
        #2;
        do_reset();

        // Single read from port 2
        cycle(4'b0100, 1'b1, 1'b0, 32'h0);
        check("single_gnt", 64'(obs_gnt), 64'h4);
        cycle(4'b0000, 1'b0, 1'b1, 32'hDEAD_BEEF);
        check("single_rv", 64'(obs_rv), 64'h4);

        // Fairness with all ports requesting, pop and push each cycle after the first
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cycle(4'b1111, 1'b1, (i != 0), 32'h100 + 32'(i));
            check("fair_order", 64'(obs_gnt), 64'(fair_exp[i]));
        end
        cycle(4'b0000, 1'b0, 1'b1, 32'h1FF);

        // Backpressure: no responses, FIFO fills after DEPTH grants
        grants = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(4'b1111, 1'b1, 1'b0, 32'h0);
            if (obs_gnt != 4'b0) grants++;
        end
        check("bp_grants", 64'(grants), 64'(DEPTH));
        check("bp_req_low", 64'(obs_req), 64'd0);
        cycle(4'b1111, 1'b1, 1'b1, 32'h11);
        check("bp_full_pop_req", 64'(obs_req), 64'd0);
        cycle(4'b1111, 1'b1, 1'b0, 32'h0);
        check("bp_resume_req", 64'(obs_req), 64'd1);
        for (int i = 0; i < 2 * DEPTH && model_q.size() > 0; i++)
            cycle(4'b0000, 1'b0, 1'b1, 32'h2000 + 32'(i));

        // In-order response routing for ports 3, 0, 2
        cycle(4'b1000, 1'b1, 1'b0, 32'h0);
        cycle(4'b0001, 1'b1, 1'b0, 32'h0);
        cycle(4'b0100, 1'b1, 1'b0, 32'h0);
        cycle(4'b0000, 1'b0, 1'b1, 32'hA);
        check("order_a", 64'(obs_rv), 64'h8);
        cycle(4'b0000, 1'b0, 1'b1, 32'hB);
        check("order_b", 64'(obs_rv), 64'h1);
        cycle(4'b0000, 1'b0, 1'b1, 32'hC);
        check("order_c", 64'(obs_rv), 64'h4);

        // Spurious response sets sticky error
        cycle(4'b0000, 1'b0, 1'b1, 32'h5);
        check("spur_rv", 64'(obs_rv), 64'h0);
        check("spur_err", 64'(err_o), 64'd1);
        cycle(4'b0000, 1'b0, 1'b0, 32'h0);
        cycle(4'b0010, 1'b1, 1'b0, 32'h0);
        check("spur_sticky", 64'(err_o), 64'd1);

        // Reset with outstanding requests
        cycle(4'b0001, 1'b1, 1'b0, 32'h0);
        do_reset();
        cycle(4'b0100, 1'b1, 1'b0, 32'h0);
        check("mid_rst_gnt", 64'(obs_gnt), 64'h4);
        cycle(4'b0000, 1'b0, 1'b1, 32'h55);
        check("mid_rst_rv", 64'(obs_rv), 64'h4);
        cycle(4'b0000, 1'b0, 1'b1, 32'h66);
        check("mid_rst_spur", 64'(err_o), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
